decoder_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 3-to-8 decoder output bus among 8 requesters.
- Selects one requester and drives the 3-bit select code (decoder `w` input) plus a registered one-hot grant equal to the decoder output.
- Holds the grant until the owner releases it.
- Sits between the requester agents and the `decoder_38` instance; the one-hot grant feeds the downstream enables.

---
 rtl/decoder_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_decoder_rr_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_rr_arbiter.sv
// Round-robin owner of a shared 3:8 decoder bus: 8 requesters, hold-until-release.
// Optional forced release after HOLD_MAX cycles when DECODER_ARB_TIMEOUT_EN is defined.
module decoder_rr_arbiter
`ifdef DECODER_ARB_TIMEOUT_EN
#(
    parameter int unsigned HOLD_MAX = 16
)
`endif
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [2:0] sel_code,
    output logic       grant_valid,
    output logic [7:0] grant,
`ifdef DECODER_ARB_TIMEOUT_EN
    output logic       timeout,
`endif
    output logic       busy
);

    localparam int unsigned NREQ = 8;
    localparam int unsigned CW   = 3;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   ptr_q;
    logic [CW-1:0]   sel_q;
    logic            gv_q;
    logic [NREQ-1:0] grant_q;

    logic [CW-1:0]   win_d;
    logic            win_vld_d;
    logic [CW-1:0]   idx;
    logic [CW-1:0]   ptr_d;
    logic            force_d;
    logic            rel_d;

    // First active request scanning upward from ptr, wrapping 7 -> 0.
    always_comb begin
        win_vld_d = 1'b0;
        win_d     = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr_q + CW'(k);
            if (!win_vld_d && req[idx]) begin
                win_vld_d = 1'b1;
                win_d     = idx;
            end
        end
    end

    // Only the owner's request bit is looked at while holding the bus.
    assign ptr_d = sel_q + CW'(1);
    assign rel_d = !req[sel_q] || force_d;

`ifdef DECODER_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] hold_q;
    logic       to_q;

    assign force_d = req[sel_q] && (hold_q == HOLD_LAST);
    assign timeout = to_q;

    // Hold counter: zero in IDLE so it starts at 0 on GRANT entry; pulse on forced release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            to_q   <= 1'b0;
        end else begin
            to_q <= 1'b0;
            if (state_q == IDLE) begin
                hold_q <= '0;
            end else if (state_q == GRANT) begin
                hold_q <= hold_q + 8'd1;
                if (force_d) begin
                    to_q <= 1'b1;
                end
            end
        end
    end
`else
    assign force_d = 1'b0;
`endif

    // Arbitration FSM with registered select code and one-hot grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gv_q    <= 1'b0;
            grant_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        sel_q   <= win_d;
                        grant_q <= {{(NREQ-1){1'b0}}, 1'b1} << win_d;
                        gv_q    <= 1'b1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel_d) begin
                        grant_q <= '0;
                        gv_q    <= 1'b0;
                        ptr_q   <= ptr_d;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    gv_q    <= 1'b0;
                end
            endcase
        end
    end

    assign sel_code    = sel_q;
    assign grant_valid = gv_q;
    assign grant       = grant_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter: reset, hold, rotation, wrap,
// no-preemption and (with DECODER_ARB_TIMEOUT_EN) forced release.
module tb_decoder_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [2:0] sel_code;
    logic       grant_valid;
    logic [7:0] grant;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

`ifdef DECODER_ARB_TIMEOUT_EN
    logic       tmo0;
    logic [7:0] req2 = 8'h00;
    logic [2:0] sel2;
    logic       gv2;
    logic [7:0] grant2;
    logic       busy2;
    logic       tmo2;

    decoder_rr_arbiter dut (
        .clk(clk), .rst(rst), .req(req),
        .sel_code(sel_code), .grant_valid(grant_valid),
        .grant(grant), .timeout(tmo0), .busy(busy)
    );

    decoder_rr_arbiter #(.HOLD_MAX(4)) dut_to (
        .clk(clk), .rst(rst), .req(req2),
        .sel_code(sel2), .grant_valid(gv2),
        .grant(grant2), .timeout(tmo2), .busy(busy2)
    );
`else
    decoder_rr_arbiter dut (
        .clk(clk), .rst(rst), .req(req),
        .sel_code(sel_code), .grant_valid(grant_valid),
        .grant(grant), .busy(busy)
    );
`endif

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [2:0] s, input logic g,
                        input logic [7:0] gn, input logic b);
        chk({tag, "_sel"},   {5'b0, sel_code},    {5'b0, s});
        chk({tag, "_gv"},    {7'b0, grant_valid}, {7'b0, g});
        chk({tag, "_grant"}, grant,               gn);
        chk({tag, "_busy"},  {7'b0, busy},        {7'b0, b});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] oh;
        int o;

        // Reset state
        tick();
        outs("reset", 3'd0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;

        // Single requester 3 held for 5 grant cycles
        req = 8'h08;
        tick();
        outs("single_g1", 3'd3, 1'b1, 8'h08, 1'b1);
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk("single_hold", grant, 8'h08);
        end
        req = 8'h00;
        tick();
        outs("single_rel", 3'd3, 1'b0, 8'h00, 1'b1);
        tick();
        outs("single_idle", 3'd3, 1'b0, 8'h00, 1'b0);
        // ptr is now 4: with 3 and 4 both requesting, 4 wins
        req = 8'h18;
        tick();
        outs("ptr4", 3'd4, 1'b1, 8'h10, 1'b1);
        req = 8'h00;
        tick();
        tick();

        // Reset mid-grant of requester 5 clears outputs without a clock edge
        req = 8'h20;
        tick();
        outs("own5", 3'd5, 1'b1, 8'h20, 1'b1);
        #2 rst = 1'b1;
        #1;
        outs("async_rst", 3'd0, 1'b0, 8'h00, 1'b0);
        #1;
        rst = 1'b0;
        req = 8'h04;
        tick();
        outs("post_rst", 3'd2, 1'b1, 8'h04, 1'b1);
        req = 8'h00;
        tick();
        tick();

        // Async reset pulse in IDLE brings ptr back to 0
        rst = 1'b1;
        #1;
        outs("rst_pulse", 3'd0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;

        // Round robin with all requesting, each owner releasing after one cycle
        req = 8'hFF;
        for (int i = 0; i < 15; i++) begin
            o  = i % 8;
            oh = 8'h01 << o;
            tick();
            outs("rr_grant", 3'(o), 1'b1, oh, 1'b1);
            req = 8'hFF & ~oh;
            tick();
            outs("rr_rel", 3'(o), 1'b0, 8'h00, 1'b1);
            req = 8'hFF;
            tick();
            outs("rr_idle", 3'(o), 1'b0, 8'h00, 1'b0);
        end

        // Wrap: ptr=7 after owner 6, req 0 and 7 -> 7 first then 0
        req = 8'h81;
        tick();
        outs("wrap7", 3'd7, 1'b1, 8'h80, 1'b1);
        req = 8'h01;
        tick();
        chk("wrap_rel", grant, 8'h00);
        tick();
        chk("wrap_gap", grant, 8'h00);
        tick();
        outs("wrap0", 3'd0, 1'b1, 8'h01, 1'b1);
        req = 8'h00;
        tick();
        tick();

        // No preemption: owner 2 keeps the bus while 0 and 7 request
        req = 8'h04;
        tick();
        outs("np_own2", 3'd2, 1'b1, 8'h04, 1'b1);
        req = 8'h85;
        tick();
        outs("np_hold", 3'd2, 1'b1, 8'h04, 1'b1);
        req = 8'bxxxx_x1xx;
        tick();
        outs("np_xreq", 3'd2, 1'b1, 8'h04, 1'b1);
        req = 8'h81;
        tick();
        outs("np_rel", 3'd2, 1'b0, 8'h00, 1'b1);
        tick();
        chk("np_gap", grant, 8'h00);
        tick();
        outs("np_next", 3'd7, 1'b1, 8'h80, 1'b1);
        req = 8'h00;
        tick();
        tick();
        outs("np_end", 3'd7, 1'b0, 8'h00, 1'b0);

`ifdef DECODER_ARB_TIMEOUT_EN
        // HOLD_MAX=4: two requesters held, forced alternation
        chk("to_idle", {gv2, tmo2, busy2, 5'b0}, 8'h00);
        req2 = 8'h03;
        for (int r = 0; r < 3; r++) begin
            oh = (r == 1) ? 8'h02 : 8'h01;
            for (int c = 0; c < 4; c++) begin
                tick();
                chk("to_grant", grant2, oh);
                chk("to_nopulse", {7'b0, tmo2}, 8'h00);
            end
            if (r < 2) begin
                tick();
                chk("to_rel", grant2, 8'h00);
                chk("to_pulse", {7'b0, tmo2}, 8'h01);
                tick();
                chk("to_gap", {grant2[6:0], tmo2}, 8'h00);
            end
        end
        req2 = 8'h00;
        chk("main_tmo", {7'b0, tmo0}, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
